pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_pkg.sv | 24 ++
 rtl/pc_unit_stack.sv | 67 ++++++
 rtl/pc_unit.sv | 132 +++++++++++++
 tb/tb_pc_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit_pkg
//  Description : Shared definitions for the program-counter unit: operation
//                encodings and the run/halt state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_unit_pkg;

  // Operation encodings; codes 6 and 7 are not listed and behave as OP_INC.
  localparam logic [2:0] OP_INC  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRC  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_t;

endpackage : pc_unit_pkg
`default_nettype wire

// File: rtl/pc_unit_stack.sv
`default_nettype none
// ============================================================================
//  Module      : pc_stack
//  Description : Return-address LIFO stack.
//  Ports       : clk, reset (async, active-low), push/push_data, pop,
//                top (most recently pushed entry), full, empty, depth.
//                The parent must not push when full or pop when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_stack #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic [DW-1:0]    depth
);

  localparam logic [DW-1:0] C_ONE = 1;

  logic [WIDTH-1:0] r_mem [STACK_DEPTH];
  logic [DW-1:0]    r_depth;
  logic [WIDTH-1:0] w_top;

  // Occupancy only; contents need no reset since depth=0 makes them invisible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth <= '0;
    end else if (push) begin
      r_depth <= r_depth + C_ONE;
    end else if (pop) begin
      r_depth <= r_depth - C_ONE;
    end
  end

  // Entry i holds the (i+1)-th pushed address; written when depth == i.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && (r_depth == DW'(i))) begin
        r_mem[i] <= push_data;
      end
    end
  end

  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (r_depth == DW'(i + 1)) begin
        w_top = r_mem[i];
      end
    end
  end

  assign top   = w_top;
  assign depth = r_depth;
  assign full  = (r_depth == DW'(STACK_DEPTH));
  assign empty = (r_depth == '0);

endmodule : pc_stack
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Program-counter unit with run/halt FSM, next-pc selection,
//                return-address stack and sticky overflow/underflow flags.
//  Ports       : clk, reset (async, active-low)
//                op, target, offset, cond, stall, resume   - control inputs
//                pc, halted, depth, stack_ovf, stack_unf   - status outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [2:0]                         op,
  input  logic [WIDTH-1:0]                   target,
  input  logic [WIDTH-1:0]                   offset,
  input  logic                               cond,
  input  logic                               stall,
  input  logic                               resume,
  output logic [WIDTH-1:0]                   pc,
  output logic                               halted,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_ovf,
  output logic                               stack_unf
);

  localparam int               DW    = $clog2(STACK_DEPTH + 1);
  localparam logic [WIDTH-1:0] C_ONE = 1;

  pc_state_t        r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_halted;
  logic             r_ovf;
  logic             r_unf;

  logic             w_active;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_pc_inc;

  assign w_pc_inc = r_pc + C_ONE;
  // An op is only executed in RUN and when not stalled.
  assign w_active = !stall && (r_state == ST_RUN);
  assign w_push   = w_active && (op == OP_CALL) && !w_full;
  assign w_pop    = w_active && (op == OP_RET)  && !w_empty;

  pc_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH),
    .DW          (DW)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_pc_inc),
    .pop       (w_pop),
    .top       (w_top),
    .full      (w_full),
    .empty     (w_empty),
    .depth     (depth)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_ADDR;
      r_halted <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        ST_RUN: begin
          case (op)
            OP_JMP:  r_pc <= target;
            OP_BRC:  r_pc <= cond ? (r_pc + offset) : w_pc_inc;
            OP_CALL: begin
              if (w_full) begin
                r_ovf    <= 1'b1;
                r_state  <= ST_HALT;
                r_halted <= 1'b1;
              end else begin
                r_pc <= target;
              end
            end
            OP_RET: begin
              if (w_empty) begin
                r_unf    <= 1'b1;
                r_state  <= ST_HALT;
                r_halted <= 1'b1;
              end else begin
                r_pc <= w_top;
              end
            end
            OP_HALT: begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
            default: r_pc <= w_pc_inc;
          endcase
        end
        ST_HALT: begin
          // Error halts are terminal until reset.
          if (resume && !r_ovf && !r_unf) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_pc     <= w_pc_inc;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign pc        = r_pc;
  assign halted    = r_halted;
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Self-checking bench for pc_unit (table, directed, random).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;
  import pc_unit_pkg::*;

  localparam int SD = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       reset = 1'b0;
  logic [2:0] op = OP_INC;
  logic [7:0] target = '0, offset = '0;
  logic       cond = 1'b0, stall = 1'b0, resume = 1'b0;
  logic [7:0] pc;
  logic       halted, stack_ovf, stack_unf;
  logic [2:0] depth;

  // 4-bit instance for the wrap-around check
  logic       reset4 = 1'b0;
  logic [2:0] op4 = OP_INC;
  logic [3:0] pc4;
  logic       halted4, ovf4, unf4;
  logic [1:0] depth4;

  pc_unit #(.WIDTH(8), .STACK_DEPTH(SD), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .op(op), .target(target), .offset(offset),
    .cond(cond), .stall(stall), .resume(resume), .pc(pc), .halted(halted),
    .depth(depth), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  pc_unit #(.WIDTH(4), .STACK_DEPTH(2), .RESET_ADDR(4'h0)) dut4 (
    .clk(clk), .reset(reset4), .op(op4), .target(4'h0), .offset(4'h0),
    .cond(1'b0), .stall(1'b0), .resume(1'b0), .pc(pc4), .halted(halted4),
    .depth(depth4), .stack_ovf(ovf4), .stack_unf(unf4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] target;
    logic [7:0] offset;
    logic       cond, stall, resume;
    logic [7:0] e_pc;
    int         e_depth;
    logic       e_halt, e_ovf, e_unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] o, logic [7:0] t, logic [7:0] f,
                              logic c, logic s, logic r, logic [7:0] ep,
                              int ed, logic eh, logic eo, logic eu);
    vec_t v;
    v.op = o; v.target = t; v.offset = f; v.cond = c; v.stall = s; v.resume = r;
    v.e_pc = ep; v.e_depth = ed; v.e_halt = eh; v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] e_pc, int e_d,
                       logic e_h, logic e_o, logic e_u);
    n_checks++;
    if (pc !== e_pc || depth !== 3'(e_d) || halted !== e_h ||
        stack_ovf !== e_o || stack_unf !== e_u) begin
      n_fail++;
      $display("FAIL %s: got pc=%02h depth=%0d halted=%b ovf=%b unf=%b, want pc=%02h depth=%0d halted=%b ovf=%b unf=%b",
               name, pc, depth, halted, stack_ovf, stack_unf, e_pc, e_d, e_h, e_o, e_u);
    end
  endtask

  task automatic drive(logic [2:0] o, logic [7:0] t, logic [7:0] f,
                       logic c, logic s, logic r);
    op = o; target = t; offset = f; cond = c; stall = s; resume = r;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between edges, checked while asserted.
  task automatic async_reset(string name);
    #2 reset = 1'b0;
    #1 check(name, 8'h00, 0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_pc;
  int m_stack[$];
  bit m_halt, m_ovf, m_unf;

  task automatic model_reset();
    m_pc = 0; m_stack.delete(); m_halt = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic model_step(int o, int t, int f, bit c, bit s, bit r);
    if (s) return;
    if (m_halt) begin
      if (r && !m_ovf && !m_unf) begin
        m_halt = 0;
        m_pc = (m_pc + 1) % 256;
      end
      return;
    end
    case (o)
      1: m_pc = t;
      2: m_pc = c ? (m_pc + f) % 256 : (m_pc + 1) % 256;
      3: if (m_stack.size() == SD) begin m_ovf = 1; m_halt = 1; end
         else begin m_stack.push_back((m_pc + 1) % 256); m_pc = t; end
      4: if (m_stack.size() == 0) begin m_unf = 1; m_halt = 1; end
         else m_pc = m_stack.pop_back();
      5: m_halt = 1;
      default: m_pc = (m_pc + 1) % 256;
    endcase
  endtask

  initial begin
    // Directed table (starts from pc=0 after reset)
    tbl.push_back(mk(OP_JMP,  8'h0A, 8'h00, 0, 0, 0, 8'h0A, 0, 0, 0, 0));
    tbl.push_back(mk(OP_BRC,  8'h00, 8'hFD, 1, 0, 0, 8'h07, 0, 0, 0, 0));
    tbl.push_back(mk(OP_JMP,  8'h0A, 8'h00, 0, 0, 0, 8'h0A, 0, 0, 0, 0));
    tbl.push_back(mk(OP_BRC,  8'h00, 8'hFD, 0, 0, 0, 8'h0B, 0, 0, 0, 0));
    tbl.push_back(mk(OP_JMP,  8'h05, 8'h00, 0, 0, 0, 8'h05, 0, 0, 0, 0));
    tbl.push_back(mk(OP_CALL, 8'h40, 8'h00, 0, 0, 0, 8'h40, 1, 0, 0, 0));
    tbl.push_back(mk(OP_RET,  8'h00, 8'h00, 0, 0, 0, 8'h06, 0, 0, 0, 0));
    tbl.push_back(mk(OP_JMP,  8'h09, 8'h00, 0, 0, 0, 8'h09, 0, 0, 0, 0));
    tbl.push_back(mk(OP_HALT, 8'h00, 8'h00, 0, 0, 0, 8'h09, 0, 1, 0, 0));
    tbl.push_back(mk(OP_JMP,  8'h33, 8'h00, 0, 0, 0, 8'h09, 0, 1, 0, 0));
    tbl.push_back(mk(OP_JMP,  8'h33, 8'h00, 0, 0, 1, 8'h0A, 0, 0, 0, 0));
    tbl.push_back(mk(OP_INC,  8'h00, 8'h00, 0, 0, 1, 8'h0B, 0, 0, 0, 0));
    tbl.push_back(mk(OP_CALL, 8'h20, 8'h00, 0, 0, 0, 8'h20, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(OP_JMP, 8'h80, 8'h00, 0, 1, 1, 8'h20, 1, 0, 0, 0));
    tbl.push_back(mk(OP_CALL, 8'h30, 8'h00, 0, 0, 0, 8'h30, 2, 0, 0, 0));
    tbl.push_back(mk(OP_RET,  8'h00, 8'h00, 0, 0, 0, 8'h21, 1, 0, 0, 0));
    tbl.push_back(mk(OP_CALL, 8'h20, 8'h00, 0, 0, 0, 8'h20, 2, 0, 0, 0));
    tbl.push_back(mk(OP_CALL, 8'h20, 8'h00, 0, 0, 0, 8'h20, 3, 0, 0, 0));
    tbl.push_back(mk(OP_CALL, 8'h20, 8'h00, 0, 0, 0, 8'h20, 4, 0, 0, 0));
    tbl.push_back(mk(OP_CALL, 8'h50, 8'h00, 0, 0, 0, 8'h20, 4, 1, 1, 0));
    tbl.push_back(mk(OP_INC,  8'h00, 8'h00, 0, 0, 1, 8'h20, 4, 1, 1, 0));
    tbl.push_back(mk(OP_RET,  8'h00, 8'h00, 0, 0, 1, 8'h20, 4, 1, 1, 0));

    // Reset state
    #3 check("reset_state", 8'h00, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].target, tbl[i].offset, tbl[i].cond,
            tbl[i].stall, tbl[i].resume);
      check($sformatf("tbl[%0d]", i), tbl[i].e_pc, tbl[i].e_depth,
            tbl[i].e_halt, tbl[i].e_ovf, tbl[i].e_unf);
    end

    // Reset from full-stack error halt, then first edge executes normally
    async_reset("reset_from_ovf");
    drive(OP_INC, 8'h00, 8'h00, 0, 0, 0);
    check("first_edge_after_reset", 8'h01, 0, 1'b0, 1'b0, 1'b0);

    // Stack-empty RET then resume ignored
    async_reset("reset_mid_run");
    drive(OP_RET, 8'h00, 8'h00, 0, 0, 0);
    check("ret_empty", 8'h00, 0, 1'b1, 1'b0, 1'b1);
    drive(OP_INC, 8'h00, 8'h00, 0, 0, 1);
    check("resume_ignored_unf", 8'h00, 0, 1'b1, 1'b0, 1'b1);
    async_reset("reset_from_unf");

    // 4-bit wrap: 20 pc values 0..15, 0..3
    #1;
    if (pc4 !== 4'h0) begin
      n_fail++;
      $display("FAIL wrap4_reset: got pc=%0h want pc=0", pc4);
    end
    n_checks++;
    @(negedge clk);
    reset4 = 1'b1;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (pc4 !== 4'(i % 16)) begin
        n_fail++;
        $display("FAIL wrap4[%0d]: got pc=%0h want pc=%0h", i, pc4, i % 16);
      end
    end

    // Randomized run against the reference model
    async_reset("reset_before_random");
    model_reset();
    for (int c = 0; c < 800; c++) begin
      logic [2:0] r_op;
      logic [7:0] r_t, r_f;
      logic       r_c, r_s, r_r;
      if ($urandom_range(0, 29) == 0) begin
        async_reset($sformatf("rand_reset[%0d]", c));
        model_reset();
      end
      r_op = 3'($urandom_range(0, 7));
      r_t  = 8'($urandom);
      r_f  = 8'($urandom);
      r_c  = 1'($urandom);
      r_s  = ($urandom_range(0, 7) == 0);
      r_r  = ($urandom_range(0, 2) == 0);
      model_step(r_op, r_t, r_f, r_c, r_s, r_r);
      drive(r_op, r_t, r_f, r_c, r_s, r_r);
      check($sformatf("rand[%0d]", c), 8'(m_pc), m_stack.size(),
            m_halt, m_ovf, m_unf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pc_unit
`default_nettype wire
